// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multi-cycle RV64 datapath.
// One shared ALU, one instruction/data memory port and one register file are sequenced
// through fetch, decode, execute, memory and writeback. The FSM supports ld, sd, R-type
// and beq. Any other opcode, or a memory access that times out, enters a sticky trap.
//
// Parameters:
//   MEM_TIMEOUT  maximum mem_ready wait cycles per access (0 = wait forever)
//   CNT_W        width of the timeout counter and of the optional perf counters
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   halt                 hold in IDLE, sampled only at instruction boundaries
//   opcode               instruction register bits [6:0]
//   zero                 ALU zero flag (the datapath gates pc_write_cond with it)
//   mem_ready            memory completes the current access this cycle
//   ctrl_ALU_op          00 add, 01 sub, 10 funct-decoded
//   alu_src_a/b, iord    datapath mux selects
//   mem_read, mem_write  memory strobes
//   ir_write, pc_write   IR load and unconditional PC update (FETCH, qualified by mem_ready)
//   pc_write_cond        PC <= ALUOut when zero
//   reg_write, mem_to_reg register file write and writeback source
//   instr_retired        one-cycle pulse on instruction completion
//   trap                 sticky illegal-opcode / timeout flag
//
// Optional feature macro MULTICYCLE_PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.

module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       ctrl_ALU_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             instr_retired,
    output logic             trap
`ifdef MULTICYCLE_PERF_CNT_EN
    , output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSd  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpBeq = 7'b1100011;

    // Count value on the last allowed wait cycle of an access.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StMemAddr, StMemRd, StMemWb,
        StMemWr, StExecR, StRWb, StBranch, StTrap
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
    state_t           after_retire;

    // Next-state values of the registered (Moore) outputs.
    logic [1:0] op_d, src_b_d;
    logic       src_a_d, iord_d, mem_read_d, mem_write_d, pc_write_cond_d;
    logic       reg_write_d, mem_to_reg_d, trap_d;
    // Registered state flags used to qualify the mem_ready-dependent strobes.
    logic       fetch_q, fetch_d, wr_q, wr_d, retire_q, retire_d;

    // The zero flag is consumed by the datapath's PC-write gating, not by this FSM.
    logic zero_unused;
    assign zero_unused = zero;

    assign timeout_hit  = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == TimeoutLast);
    assign after_retire = halt ? StIdle : StFetch;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle:    if (!halt) state_d = StFetch;
            StFetch:   begin
                if (mem_ready)        state_d = StDecode;
                else if (timeout_hit) state_d = StTrap;
            end
            StDecode:  begin
                unique case (opcode)
                    OpLd, OpSd: state_d = StMemAddr;
                    OpR:        state_d = StExecR;
                    OpBeq:      state_d = StBranch;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAddr: state_d = (opcode == OpSd) ? StMemWr : StMemRd;
            StMemRd:   begin
                if (mem_ready)        state_d = StMemWb;
                else if (timeout_hit) state_d = StTrap;
            end
            StMemWb:   state_d = after_retire;
            StMemWr:   begin
                if (mem_ready)        state_d = after_retire;
                else if (timeout_hit) state_d = StTrap;
            end
            StExecR:   state_d = StRWb;
            StRWb:     state_d = after_retire;
            StBranch:  state_d = after_retire;
            StTrap:    state_d = StTrap;
            default:   state_d = StIdle;
        endcase

        // Clear on entry to any state; count stalled cycles while waiting on memory.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == StFetch || state_q == StMemRd || state_q == StMemWr)
                     && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        op_d            = 2'b00;
        src_a_d         = 1'b0;
        src_b_d         = 2'b00;
        iord_d          = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        pc_write_cond_d = 1'b0;
        reg_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        trap_d          = 1'b0;
        fetch_d         = 1'b0;
        wr_d            = 1'b0;
        retire_d        = 1'b0;

        unique case (state_d)
            StFetch:   begin
                mem_read_d = 1'b1;
                src_b_d    = 2'b01;
                fetch_d    = 1'b1;
            end
            StDecode:  src_b_d = 2'b10;
            StMemAddr: begin
                src_a_d = 1'b1;
                src_b_d = 2'b10;
            end
            StMemRd:   begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            StMemWb:   begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                retire_d     = 1'b1;
            end
            StMemWr:   begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
                wr_d        = 1'b1;
            end
            StExecR:   begin
                src_a_d = 1'b1;
                op_d    = 2'b10;
            end
            StRWb:     begin
                reg_write_d = 1'b1;
                retire_d    = 1'b1;
            end
            StBranch:  begin
                src_a_d         = 1'b1;
                op_d            = 2'b01;
                pc_write_cond_d = 1'b1;
                retire_d        = 1'b1;
            end
            StTrap:    trap_d = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ctrl_ALU_op   <= 2'b00;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            iord          <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            pc_write_cond <= 1'b0;
            reg_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            trap          <= 1'b0;
            fetch_q       <= 1'b0;
            wr_q          <= 1'b0;
            retire_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ctrl_ALU_op   <= op_d;
            alu_src_a     <= src_a_d;
            alu_src_b     <= src_b_d;
            iord          <= iord_d;
            mem_read      <= mem_read_d;
            mem_write     <= mem_write_d;
            pc_write_cond <= pc_write_cond_d;
            reg_write     <= reg_write_d;
            mem_to_reg    <= mem_to_reg_d;
            trap          <= trap_d;
            fetch_q       <= fetch_d;
            wr_q          <= wr_d;
            retire_q      <= retire_d;
        end
    end

    // Completion strobes depend on mem_ready; a reset in the same cycle aborts the access.
    assign ir_write      = fetch_q & mem_ready & ~rst;
    assign pc_write      = fetch_q & mem_ready & ~rst;
    assign instr_retired = retire_q | (wr_q & mem_ready & ~rst);

`ifdef MULTICYCLE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != StIdle && state_q != StTrap) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_retired) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A reference model expands each instruction
// (kind, wait counts, halt at the boundary) into the list of expected per-cycle output
// vectors, and every cycle is compared against it.

module tb_multicycle_ctrl;

    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           halt = 1'b1;
    logic [6:0]     opcode = 7'b0;
    logic           zero = 1'b0;
    logic           mem_ready = 1'b0;
    logic [1:0]     ctrl_ALU_op;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic           iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
    logic           reg_write, mem_to_reg, instr_retired, trap;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CW-1:0]  cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .halt(halt), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ctrl_ALU_op(ctrl_ALU_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_retired(instr_retired),
        .trap(trap)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0] op;
        logic       src_a;
        logic [1:0] src_b;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retired;
        logic       trap;
    } outs_t;

    typedef struct {
        string tag;
        logic  ready;
        logic  hlt;
        outs_t exp;
        outs_t msk;
        logic  active;
    } step_t;

    localparam int KLd = 0, KSd = 1, KR = 2, KBeq = 3, KIll = 4;

    step_t         q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] m_cyc = '0;
    logic [CW-1:0] m_ret = '0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Strobes are always checked; selects only where the intended value is defined.
    function automatic outs_t smask();
        outs_t o = '0;
        o.mem_read = 1'b1; o.mem_write = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        o.pc_write_cond = 1'b1; o.reg_write = 1'b1; o.retired = 1'b1; o.trap = 1'b1;
        return o;
    endfunction

    function automatic outs_t selmask();
        outs_t o = smask();
        o.op = 2'b11; o.src_a = 1'b1; o.src_b = 2'b11;
        return o;
    endfunction

    function automatic outs_t sel(input logic [1:0] op, input logic a, input logic [1:0] b);
        outs_t o = '0;
        o.op = op; o.src_a = a; o.src_b = b;
        return o;
    endfunction

    task automatic push(input string tag, input logic rdy, input logic hl, input outs_t e,
                        input outs_t m, input logic act);
        step_t s;
        s.tag = tag; s.ready = rdy; s.hlt = hl; s.exp = e; s.msk = m; s.active = act;
        q.push_back(s);
    endtask

    task automatic check_outs(input string tag, input outs_t e, input outs_t m);
        logic [14:0] obs, ev, mv;
        obs = {ctrl_ALU_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
               pc_write, pc_write_cond, reg_write, mem_to_reg, instr_retired, trap};
        ev = e;
        mv = m;
        checks++;
        assert ((obs & mv) === (ev & mv)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h mask=%h", tag, obs, ev, mv);
        end
`ifdef MULTICYCLE_PERF_CNT_EN
        checks++;
        assert (cycle_cnt === m_cyc) else begin
            errors++;
            $error("FAIL %s_cycle_cnt observed=%0d expected=%0d", tag, cycle_cnt, m_cyc);
        end
        checks++;
        assert (instret_cnt === m_ret) else begin
            errors++;
            $error("FAIL %s_instret_cnt observed=%0d expected=%0d", tag, instret_cnt, m_ret);
        end
`endif
    endtask

    task automatic run_queue();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.ready;
            halt      = s.hlt;
            #1;
            check_outs(s.tag, s.exp, s.msk);
            if (s.active) m_cyc++;
            if (s.exp.retired) m_ret++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; halt = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        m_cyc = '0;
        m_ret = '0;
        check_outs("reset", '0, selmask());
        rst = 1'b0;
    endtask

    // Expected cycle list for one instruction: fetch (wf waits), decode, then the
    // per-kind tail; wm waits on the data access; hend = halt at the final cycle;
    // tmo = data access never completes and must time out into the trap.
    task automatic build(input int kind, input int wf, input int wm, input logic hend,
                         input logic tmo);
        outs_t e, m;
        e = sel(2'b00, 1'b0, 2'b01); e.mem_read = 1'b1;
        m = selmask(); m.iord = 1'b1;
        for (int i = 0; i < wf; i++) push("fetch_wait", 1'b0, rb(), e, m, 1'b1);
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        push("fetch", 1'b1, rb(), e, m, 1'b1);
        push("decode", rb(), rb(), sel(2'b00, 1'b0, 2'b10), selmask(), 1'b1);
        case (kind)
            KLd, KSd: begin
                push("mem_addr", rb(), rb(), sel(2'b00, 1'b1, 2'b10), selmask(), 1'b1);
                e = '0; e.iord = 1'b1;
                if (kind == KLd) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                m = smask(); m.iord = 1'b1;
                for (int i = 0; i < wm; i++) push("mem_wait", 1'b0, rb(), e, m, 1'b1);
                if (tmo) begin
                    e = '0; e.trap = 1'b1;
                    push("mem_timeout", rb(), rb(), e, smask(), 1'b0);
                    return;
                end
                if (kind == KLd) begin
                    push("mem_rd", 1'b1, rb(), e, m, 1'b1);
                    e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.retired = 1'b1;
                    m = smask(); m.mem_to_reg = 1'b1;
                    push("mem_wb", rb(), hend, e, m, 1'b1);
                end else begin
                    e.retired = 1'b1;
                    push("mem_wr", 1'b1, hend, e, m, 1'b1);
                end
            end
            KR: begin
                push("exec_r", rb(), rb(), sel(2'b10, 1'b1, 2'b00), selmask(), 1'b1);
                e = '0; e.reg_write = 1'b1; e.retired = 1'b1;
                m = smask(); m.mem_to_reg = 1'b1;
                push("r_wb", rb(), hend, e, m, 1'b1);
            end
            KBeq: begin
                e = sel(2'b01, 1'b1, 2'b00); e.pc_write_cond = 1'b1; e.retired = 1'b1;
                push("branch", rb(), hend, e, selmask(), 1'b1);
            end
            default: return;
        endcase
        if (hend) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                push("idle_halt", rb(), 1'b1, '0, smask(), 1'b0);
            push("idle_go", rb(), 1'b0, '0, smask(), 1'b0);
        end
    endtask

    task automatic run_instr(input int kind, input int wf, input int wm, input logic hend,
                             input logic tmo, input logic z);
        case (kind)
            KLd:     opcode = 7'b0000011;
            KSd:     opcode = 7'b0100011;
            KR:      opcode = 7'b0110011;
            KBeq:    opcode = 7'b1100011;
            default: opcode = 7'b0010011;
        endcase
        zero = z;
        build(kind, wf, wm, hend, tmo);
        run_queue();
    endtask

    task automatic push_trap(input int n);
        outs_t e;
        e = '0; e.trap = 1'b1;
        for (int i = 0; i < n; i++) push("trap_hold", rb(), rb(), e, smask(), 1'b0);
    endtask

    initial begin
        outs_t e, m;

        // Reset, then hold in IDLE with halt, then release.
        do_reset();
        for (int i = 0; i < 5; i++) push("idle_halt", rb(), 1'b1, '0, selmask(), 1'b0);
        push("idle_go", rb(), 1'b0, '0, selmask(), 1'b0);
        run_queue();

        // Directed instructions.
        run_instr(KR, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(KLd, 0, 2, 1'b0, 1'b0, 1'b0);
        run_instr(KSd, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(KBeq, 0, 0, 1'b1, 1'b0, 1'b1);
        // One wait short of the limit on both accesses: ready on the limit cycle wins.
        run_instr(KLd, 3, 3, 1'b0, 1'b0, 1'b0);
        run_instr(KSd, 3, 3, 1'b1, 1'b0, 1'b0);

        // Random instruction stream.
        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0, rb());
        end

        // Illegal opcode: sticky trap, halt ignored, cleared only by reset.
        run_instr(KIll, 0, 0, 1'b0, 1'b0, 1'b0);
        push_trap(20);
        run_queue();
        do_reset();

        // Fetch timeout: four stalled cycles, trap on the fifth, no ir_write.
        push("idle_go", 1'b0, 1'b0, '0, smask(), 1'b0);
        e = sel(2'b00, 1'b0, 2'b01); e.mem_read = 1'b1;
        m = selmask(); m.iord = 1'b1;
        for (int i = 0; i < 4; i++) push("fetch_stall", 1'b0, rb(), e, m, 1'b1);
        e = '0; e.trap = 1'b1;
        push("fetch_timeout", 1'b0, rb(), e, smask(), 1'b0);
        push_trap(4);
        run_queue();
        do_reset();

        // Data-read timeout.
        push("idle_go", rb(), 1'b0, '0, smask(), 1'b0);
        run_queue();
        run_instr(KLd, 1, 4, 1'b0, 1'b1, 1'b0);
        push_trap(3);
        run_queue();
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
